// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants for the registered CLA adder and its result FIFO
package cla_pkg;

  localparam int CLA_WIDTH     = 5;
  localparam int CLA_RES_WIDTH = 6;
  localparam int CLA_LATENCY   = 2;
  localparam int CLA_DEPTH     = 4;

  typedef logic [CLA_RES_WIDTH-1:0] cla_res_t;

endpackage

// File: rtl/cla_result_fifo_if.sv
// rtl/cla_result_fifo_if.sv - operand-side credit and result-side valid/ready bundle
interface cla_result_fifo_if import cla_pkg::*; #(
  parameter int WIDTH = CLA_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_data;

  // FIFO side
  modport slave (
    input  in_valid, sum, cout, out_ready,
    output in_ready, out_valid, out_data
  );

  // operand source / adder / consumer side
  modport master (
    output in_valid, sum, cout, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/cla_valid_delay.sv
// rtl/cla_valid_delay.sv - tracks operand valids through the adder pipeline
module cla_valid_delay import cla_pkg::*; #(
  parameter  int LATENCY = CLA_LATENCY,
  localparam int IW      = $clog2(LATENCY + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          tap,
  output logic [IW-1:0] inflight
);

  logic [LATENCY-1:0] vpipe;

  // shift the valid flag alongside the adder's data registers; reset drops in-flight ops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
      end
    end
  end

  assign tap = vpipe[LATENCY-1];

  // count of operations still travelling through the adder
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + IW'(vpipe[i]);
    end
  end

endmodule

// File: rtl/cla_result_fifo.sv
// rtl/cla_result_fifo.sv - captures valid CLA results into a circular FIFO with credit output
module cla_result_fifo import cla_pkg::*; #(
  parameter  int WIDTH   = CLA_WIDTH,
  parameter  int LATENCY = CLA_LATENCY,
  parameter  int DEPTH   = CLA_DEPTH,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cla_result_fifo_if.slave     bus,
  output logic [CW-1:0]        count,
  output logic                 drop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(LATENCY + 1);

  logic [WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            tap;
  logic [IW-1:0]   inflight;
  logic            full;
  logic            pop;
  logic            do_write;
  logic            do_drop;

  cla_valid_delay #(
    .LATENCY (LATENCY)
  ) u_valid_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.in_valid),
    .tap      (tap),
    .inflight (inflight)
  );

  assign full          = (count == CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = mem[rd_ptr];
  assign pop           = bus.out_valid && bus.out_ready;
  // a full FIFO still accepts a result when the head leaves in the same cycle
  assign do_write      = tap && (!full || pop);
  assign do_drop       = tap && full && !pop;

  // credit counts results already stored plus those the adder will still deliver
  assign bus.in_ready  = (32'(count) + 32'(inflight)) < 32'(DEPTH);

  // result storage; contents are not reset, visibility is governed by count
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= {bus.cout, bus.sum};
    end
  end

  // pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_write, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (do_drop) begin
        drop_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cla_result_fifo.sv
// tb/tb_cla_result_fifo.sv - directed scoreboard bench for cla_result_fifo
module tb_cla_result_fifo;
  import cla_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [$clog2(CLA_DEPTH):0]  count;
  logic                        drop_err;
  logic [CLA_WIDTH-1:0]        a, b, a_r, b_r;
  logic [CLA_RES_WIDTH-1:0]    exp_q [$];
  int                          n_assert = 0;
  int                          n_fail   = 0;
  int                          idx;
  logic [CLA_WIDTH-1:0]        opa [4];
  logic [CLA_WIDTH-1:0]        opb [4];

  cla_result_fifo_if #(.WIDTH(CLA_WIDTH)) bus ();

  cla_result_fifo #(
    .WIDTH   (CLA_WIDTH),
    .LATENCY (CLA_LATENCY),
    .DEPTH   (CLA_DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .count    (count),
    .drop_err (drop_err)
  );

  always #5 clk = ~clk;

  // adder model: input register then output register, never reset
  always @(posedge clk) begin
    a_r <= a;
    b_r <= b;
    {bus.cout, bus.sum} <= 6'(a_r) + 6'(b_r);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // compare any pop about to happen at the next edge, then advance one cycle
  task automatic step();
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("pop_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [CLA_WIDTH-1:0] ai, input logic [CLA_WIDTH-1:0] bi,
                       input bit push);
    bus.in_valid = 1'b1;
    a = ai;
    b = bi;
    if (push) exp_q.push_back(6'(ai) + 6'(bi));
  endtask

  task automatic drain(input string tag);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 24 && exp_q.size() != 0; k++) step();
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    opa = '{5'd1, 5'd3, 5'd10, 5'd31};
    opb = '{5'd2, 5'd4, 5'd20, 5'd31};
    a = '0;
    b = '0;
    bus.out_ready = 1'b0;

    // reset held with in_valid asserted
    rst_n = 1'b0;
    issue(5'd7, 5'd7, 1'b0);
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_drop_err", 32'(drop_err), 32'd0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("rst_no_stale_write", 32'(bus.out_valid), 32'd0);
    chk("rst_no_stale_count", 32'(count), 32'd0);

    // single operation latency
    bus.out_ready = 1'b1;
    issue(5'd31, 5'd1, 1'b1);
    step();
    bus.in_valid = 1'b0;
    chk("single_e0_valid", 32'(bus.out_valid), 32'd0);
    step();
    chk("single_e1_valid", 32'(bus.out_valid), 32'd0);
    step();
    chk("single_e2_valid", 32'(bus.out_valid), 32'd1);
    chk("single_e2_data", 32'(bus.out_data), 32'h20);
    chk("single_e2_count", 32'(count), 32'd1);
    step();
    chk("single_e3_count", 32'(count), 32'd0);
    chk("single_e3_valid", 32'(bus.out_valid), 32'd0);
    chk("single_drained", 32'(exp_q.size()), 32'd0);

    // backpressure with in_ready-gated issue
    bus.out_ready = 1'b0;
    idx = 0;
    for (int t = 0; t < 12 && idx < 4; t++) begin
      if (bus.in_ready) begin
        issue(opa[idx], opb[idx], 1'b1);
        idx++;
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
    end
    bus.in_valid = 1'b0;
    chk("bp_issued", 32'(idx), 32'd4);
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < 8 && count != 4; k++) step();
    chk("bp_count_full", 32'(count), 32'd4);
    chk("bp_drop_err", 32'(drop_err), 32'd0);
    chk("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
    chk("bp_head", 32'(bus.out_data), 32'd3);
    drain("bp_drain");
    chk("bp_count_empty", 32'(count), 32'd0);

    // overflow: five issues ignoring credit, fifth result is discarded
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue(5'(i * 5), 5'd3, i < 4);
      step();
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("drop_count", 32'(count), 32'd4);
    chk("drop_err_set", 32'(drop_err), 32'd1);
    drain("drop_drain");
    chk("drop_count_empty", 32'(count), 32'd0);
    chk("drop_no_fifth", 32'(bus.out_valid), 32'd0);
    chk("drop_err_sticky", 32'(drop_err), 32'd1);

    // full FIFO with simultaneous write and pop across pointer wrap
    do_reset();
    chk("wp_drop_cleared", 32'(drop_err), 32'd0);
    for (int t = 0; t < 14; t++) begin
      if (t < 12) issue(5'(t * 3), 5'(t * 7 + 1), 1'b1);
      else bus.in_valid = 1'b0;
      bus.out_ready = (t >= 6);
      step();
      if (t >= 5) chk($sformatf("wp_count_t%0d", t), 32'(count), 32'd4);
    end
    chk("wp_drop_err", 32'(drop_err), 32'd0);
    drain("wp_drain");
    chk("wp_count_empty", 32'(count), 32'd0);

    // reset while an operation is in flight
    bus.out_ready = 1'b0;
    issue(5'd5, 5'd6, 1'b0);
    step();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("mid_rst_e2_valid", 32'(bus.out_valid), 32'd0);
    step();
    chk("mid_rst_e3_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_result_fifo.md
Name: cla_result_fifo

Overview:
Downstream stage of the 5-bit registered CLA adder. It tracks which adder operations are valid through the adder's fixed 2-cycle latency and captures each valid {cout,sum} result into a small circular FIFO. Results are presented to the consumer over a valid/ready handshake. Because the adder cannot stall, the block issues a credit-style in_ready to the operand source.

Parameters:
WIDTH, 5, adder operand/sum width
LATENCY, 2, cycles from in_valid sampled to adder sum/cout registered (adder input reg + output reg)
DEPTH, 4, FIFO entries; power of two, >=2

Ports:
clk  input  1  rising-edge clock, shared with adder
rst_n  input  1  synchronous active-low reset
in_valid  input  1  high in the cycle a/b are driven to the adder
in_ready  output  1  advisory credit: source may assert in_valid this cycle without loss
sum  input  WIDTH  adder sum output
cout  input  1  adder carry-out
out_valid  output  1  FIFO head holds a result
out_ready  input  1  consumer accepts head
out_data  output  WIDTH+1  {cout,sum} at head
count  output  log2(DEPTH)+1  stored entries, 0..DEPTH
drop_err  output  1  sticky: a result was discarded

Behaviour:
- Reset (rst_n=0 at a clk edge): vpipe, rd_ptr, wr_ptr, count, drop_err cleared. Outputs after reset: out_valid=0, count=0, in_ready=1, drop_err=0, out_data=don't-care (mem not reset).
- Valid delay: vpipe[0]<=in_valid; vpipe[i]<=vpipe[i-1]. in_valid is taken regardless of in_ready, because the adder cannot refuse.
- Write: at an edge where vpipe[LATENCY-1]=1, sample {cout,sum} into mem[wr_ptr]. Timing: in_valid sampled at edge k, written at edge k+2, out_valid=1 after edge k+2.
- inflight = popcount(vpipe).
- in_ready = (count + inflight) < DEPTH, computed combinationally from registers only. This is conservative: honouring it guarantees no drop even with out_ready=0.
- Pop: out_valid && out_ready at an edge advances rd_ptr.
- out_valid = (count != 0); out_data = mem[rd_ptr]. No write-to-read bypass; minimum one cycle from write to visibility.
- Count: +1 on write only, -1 on pop only, unchanged on simultaneous write+pop.
- Full with write and pop in the same edge: both occur, count stays DEPTH, order preserved.
- Full with write and no pop: result discarded, pointers and count unchanged, drop_err<=1. drop_err is sticky until reset.
- Empty: pop impossible because out_valid=0. A write while empty makes out_valid=1 next cycle.
- Pointers wrap modulo DEPTH. FIFO order equals in_valid issue order.
- Reset mid-flight: in-flight valids are lost. Adder registers are not reset, so any stale sum/cout they produce is ignored because vpipe=0.
- No arithmetic on data; {cout,sum} is stored bit-exact.

Decomposition:
- Shared package cla_pkg: CLA_WIDTH=5, CLA_RES_WIDTH=6, CLA_LATENCY=2. The adder and this block both reference these.
- One sub-module, cla_valid_delay: LATENCY-deep shift register with rst_n clear. Outputs are the tap vpipe[LATENCY-1] and the inflight popcount.
- FIFO storage and pointers live in the top block.

Test Plan:
- Reset: hold rst_n=0 two cycles, with in_valid=1 -> out_valid=0, count=0, in_ready=1, drop_err=0. After release, no spurious write from stale adder output.
- Single op: a=31, b=1, in_valid pulse at edge 0, out_ready=1 -> out_valid=1 after edge 2, out_data=6'b100000. Popped at edge 3, count returns to 0.
- Backpressure: out_ready=0, source drives in_valid every cycle gated by in_ready, with operands (1,2),(3,4),(10,20),(31,31). Expected:
  - in_ready falls after 4th issue; count reaches 4, drop_err=0.
  - Drain order out_data = 3, 7, 30, 62.
- Drop: out_ready=0, 5 consecutive in_valid ignoring in_ready -> count=4, drop_err=1 and stays 1. Only the first 4 results drain.
- Full write+pop: FIFO full, out_ready=1 with continuous issue -> count holds 4, pointers wrap past DEPTH, output sequence matches issue sequence over 12 ops.
- Reset mid-flight: in_valid at edge 0, rst_n=0 at edge 1 -> no write at edge 2, out_valid stays 0.
